// File: rtl/frame_buffer_filt.sv
// ============================================================================
// Module   : frame_buffer_filt
// Brief    : Single-clock frame buffer with auto-increment write pointer,
//            built-in clear engine and a 2-stage filtered read pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_buffer_filt #(
    parameter int                      AW             = 15,
    parameter int                      DEPTH          = 19200,
    parameter int                      RW             = 1,
    parameter int                      GW             = 1,
    parameter int                      BW             = 1,
    parameter logic [RW+GW+BW-1:0]     CLEAR_VAL      = '0,
    parameter int                      CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  regwrite,
    input  logic                  wr_auto,
    input  logic                  frame_start,
    input  logic [AW-1:0]         addr_in,
    input  logic [RW+GW+BW-1:0]   data_in,
    input  logic                  rd_en,
    input  logic [AW-1:0]         addr_out,
    input  logic [7:0]            filter,
    input  logic                  clear_req,
    output logic [RW+GW+BW-1:0]   data_out,
    output logic                  rd_valid,
    output logic                  busy,
    output logic [AW-1:0]         wr_ptr
);

    localparam int DW = RW + GW + BW;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;
    localparam logic [0:0] c_RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

    localparam logic [AW:0]   c_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_LAST  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] c_ONE   = AW'(1);

    localparam logic [DW-1:0] c_MASK_R = {{RW{1'b1}}, {(GW+BW){1'b0}}};
    localparam logic [DW-1:0] c_MASK_G = {{RW{1'b0}}, {GW{1'b1}}, {BW{1'b0}}};
    localparam logic [DW-1:0] c_MASK_B = {{(RW+GW){1'b0}}, {BW{1'b1}}};

    logic [DW-1:0] ram [0:DEPTH-1];

    logic [0:0]    r_state;
    logic [AW-1:0] r_clr_cnt;
    logic [AW-1:0] r_wr_ptr;
    logic          w_busy;

    logic [AW-1:0] w_ptr_base;
    logic [AW-1:0] w_tgt;
    logic          w_ext_we;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;

    logic          r_s1_valid;
    logic [DW-1:0] r_s1_data;
    logic [7:0]    r_s1_filter;
    logic          r_s1_zero;
    logic [DW-1:0] w_filt;
    logic          w_mono;
    logic [DW-1:0] r_data_out;
    logic          r_rd_valid;

    assign w_busy   = (r_state == S_CLEAR);
    assign busy     = w_busy;
    assign wr_ptr   = r_wr_ptr;
    assign data_out = r_data_out;
    assign rd_valid = r_rd_valid;

    // frame_start redirects a same-cycle auto write to address 0
    assign w_ptr_base = frame_start ? '0 : r_wr_ptr;
    assign w_tgt      = wr_auto ? w_ptr_base : addr_in;
    assign w_ext_we   = !w_busy && regwrite && ({1'b0, w_tgt} < c_DEPTH);

    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_tgt;
        w_wdata = data_in;
        if (w_busy) begin
            w_we    = 1'b1;
            w_waddr = r_clr_cnt;
            w_wdata = CLEAR_VAL;
        end else if (w_ext_we) begin
            w_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_RST_STATE;
            r_clr_cnt <= '0;
        end else if (r_state == S_CLEAR) begin
            if (r_clr_cnt == c_LAST) begin
                r_state   <= S_IDLE;
                r_clr_cnt <= '0;
            end else begin
                r_clr_cnt <= r_clr_cnt + c_ONE;
            end
        end else if (clear_req) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
        end else if (!w_busy && regwrite && wr_auto) begin
            r_wr_ptr <= (w_ptr_base == c_LAST) ? '0 : w_ptr_base + c_ONE;
        end else if (frame_start) begin
            r_wr_ptr <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            ram[w_waddr] <= w_wdata;
        end
    end

    // Stage 1: RAM read returns pre-write data on a same-address collision
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_filter <= '0;
            r_s1_zero   <= 1'b0;
        end else begin
            r_s1_valid <= rd_en;
            if (rd_en) begin
                r_s1_data   <= ram[addr_out];
                r_s1_filter <= filter;
                r_s1_zero   <= w_busy || ({1'b0, addr_out} >= c_DEPTH);
            end
        end
    end

    assign w_mono = (r_s1_data[DW-1] & r_s1_data[BW+GW-1]) |
                    (r_s1_data[DW-1] & r_s1_data[BW-1])    |
                    (r_s1_data[BW+GW-1] & r_s1_data[BW-1]);

    always_comb begin
        w_filt = r_s1_data;
        case (r_s1_filter)
            8'd1:    w_filt = ~r_s1_data;
            8'd2:    w_filt = r_s1_data & c_MASK_R;
            8'd3:    w_filt = r_s1_data & c_MASK_G;
            8'd4:    w_filt = r_s1_data & c_MASK_B;
            8'd5:    w_filt = w_mono ? '1 : '0;
            default: w_filt = r_s1_data;
        endcase
    end

    // Stage 2: data_out holds its last value when no read is in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_data_out <= r_s1_zero ? '0 : w_filt;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_frame_buffer_filt.sv
// ============================================================================
// Module   : tb_frame_buffer_filt
// Brief    : Self-checking bench for frame_buffer_filt (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_buffer_filt;

    localparam int AW    = 15;
    localparam int DEPTH = 19200;
    localparam int DW    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          regwrite = 1'b0;
    logic          wr_auto = 1'b0;
    logic          frame_start = 1'b0;
    logic [AW-1:0] addr_in = '0;
    logic [DW-1:0] data_in = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] addr_out = '0;
    logic [7:0]    filter = '0;
    logic          clear_req = 1'b0;
    logic [DW-1:0] data_out;
    logic          rd_valid;
    logic          busy;
    logic [AW-1:0] wr_ptr;

    frame_buffer_filt dut (
        .clk         (clk),
        .reset       (reset),
        .regwrite    (regwrite),
        .wr_auto     (wr_auto),
        .frame_start (frame_start),
        .addr_in     (addr_in),
        .data_in     (data_in),
        .rd_en       (rd_en),
        .addr_out    (addr_out),
        .filter      (filter),
        .clear_req   (clear_req),
        .data_out    (data_out),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .wr_ptr      (wr_ptr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            cyc;
        logic [DW-1:0] exp;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [7:0]    filt;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vecs[12];

    // Scoreboard: every read must come back exactly two cycles after issue
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc + 2 < cyc) begin
            checks++;
            errors++;
            $display("FAIL read_latency: no output for read issued in cycle %0d (now %0d)", sb[0].cyc, cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc + 2 == cyc) begin
            checks++;
            if (rd_valid !== 1'b1 || data_out !== sb[0].exp) begin
                errors++;
                $display("FAIL read_data (issued cycle %0d): got valid=%b data=%b expected valid=1 data=%b",
                         sb[0].cyc, rd_valid, data_out, sb[0].exp);
            end
            void'(sb.pop_front());
        end else if (rd_valid !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid at cycle %0d: got rd_valid=%b expected 0", cyc, rd_valid);
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        regwrite = 1'b1; wr_auto = 1'b0; addr_in = a; data_in = d;
        tick();
        regwrite = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [7:0] f, input logic [DW-1:0] e);
        rd_en = 1'b1; addr_out = a; filter = f;
        sb.push_back('{cyc, e});
        tick();
        rd_en = 1'b0;
    endtask

    task automatic drain();
        repeat (4) tick();
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        while (busy && n < DEPTH + 10) begin
            n++;
            tick();
        end
        chk(name, n, DEPTH);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 15'd5, 3'b101, 8'd0, 3'b101};
        vecs[1]  = '{1'b0, 15'd5, 3'b000, 8'd1, 3'b010};
        vecs[2]  = '{1'b0, 15'd5, 3'b000, 8'd2, 3'b100};
        vecs[3]  = '{1'b0, 15'd5, 3'b000, 8'd5, 3'b111};
        vecs[4]  = '{1'b0, 15'd5, 3'b000, 8'd3, 3'b000};
        vecs[5]  = '{1'b0, 15'd5, 3'b000, 8'd4, 3'b001};
        vecs[6]  = '{1'b0, 15'd5, 3'b000, 8'd6, 3'b101};
        vecs[7]  = '{1'b1, 15'd6, 3'b011, 8'd3, 3'b010};
        vecs[8]  = '{1'b0, 15'd6, 3'b000, 8'd5, 3'b111};
        vecs[9]  = '{1'b0, 15'd6, 3'b000, 8'd1, 3'b100};
        vecs[10] = '{1'b1, 15'd9, 3'b001, 8'd5, 3'b000};
        vecs[11] = '{1'b0, 15'd6, 3'b000, 8'd0, 3'b011};

        // Reset values
        reset = 1'b1;
        repeat (2) tick();
        chk("reset_busy", busy, 1);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_data_out", data_out, 0);
        chk("reset_wr_ptr", wr_ptr, 0);

        // Reset mid-sweep restarts a full sweep
        reset = 1'b0;
        repeat (1000) tick();
        chk("busy_mid_sweep", busy, 1);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        count_busy("sweep_len_after_reset");
        do_read(15'd100, 8'd0, 3'b000);
        drain();

        // Filter table with back-to-back reads
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].wdata);
            do_read(vecs[i].addr, vecs[i].filt, vecs[i].exp);
        end
        drain();
        chk("data_out_hold", data_out, 3'b011);

        // Out-of-range write and read
        do_write(15'd19200, 3'b111);
        do_read(15'd19200, 8'd0, 3'b000);
        do_read(15'd19200, 8'd1, 3'b000);
        do_read(15'd32767, 8'd5, 3'b000);
        drain();

        // Read/write collision returns old data
        do_write(15'd7, 3'b001);
        regwrite = 1'b1; wr_auto = 1'b0; addr_in = 15'd7; data_in = 3'b110;
        do_read(15'd7, 8'd0, 3'b001);
        regwrite = 1'b0;
        do_read(15'd7, 8'd0, 3'b110);
        drain();

        // Auto-write sweep with wrap
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("frame_start_ptr", wr_ptr, 0);
        for (int i = 0; i <= DEPTH; i++) begin
            regwrite = 1'b1; wr_auto = 1'b1; data_in = 3'(i);
            tick();
        end
        regwrite = 1'b0; wr_auto = 1'b0;
        chk("wr_ptr_wrap", wr_ptr, 1);
        do_read(15'd0, 8'd0, 3'b000);
        do_read(15'd19199, 8'd0, 3'b111);
        do_read(15'd1, 8'd0, 3'b001);
        drain();

        // frame_start coincident with an auto write
        regwrite = 1'b1; wr_auto = 1'b1; data_in = 3'b010;
        repeat (2) tick();
        chk("wr_ptr_advance", wr_ptr, 3);
        frame_start = 1'b1; data_in = 3'b101;
        tick();
        frame_start = 1'b0; regwrite = 1'b0; wr_auto = 1'b0;
        chk("fs_auto_ptr", wr_ptr, 1);
        do_read(15'd0, 8'd0, 3'b101);
        do_read(15'd2, 8'd0, 3'b010);
        drain();

        // Clear request: writes and second request ignored mid-sweep
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        begin
            int n = 0;
            while (busy && n < DEPTH + 10) begin
                if (n == 2) begin
                    rd_en = 1'b1; addr_out = 15'd5; filter = 8'd0;
                    sb.push_back('{cyc, 3'b000});
                end
                if (n == 10) begin
                    regwrite = 1'b1; wr_auto = 1'b0; addr_in = 15'd3; data_in = 3'b111;
                end
                if (n == 12) begin
                    regwrite = 1'b1; wr_auto = 1'b1; data_in = 3'b111;
                end
                if (n == 20) clear_req = 1'b1;
                n++;
                tick();
                rd_en = 1'b0; regwrite = 1'b0; wr_auto = 1'b0; clear_req = 1'b0;
            end
            chk("clear_sweep_len", n, DEPTH);
        end
        chk("wr_ptr_held_busy", wr_ptr, 1);
        do_read(15'd3, 8'd0, 3'b000);
        do_read(15'd0, 8'd0, 3'b000);
        drain();

        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
